// File: rtl/tl_next_state_w_left.sv
// Next-state logic for the left-turn traffic light controller. Owns the per-phase dwell timer
// and the sticky left-turn request latches; the state register itself lives downstream.
module tl_next_state_w_left #(
    parameter int unsigned G_MIN = 4,
    parameter int unsigned G_MAX = 16,
    parameter int unsigned Y_T   = 2,
    parameter int unsigned L_T   = 4,
    parameter int unsigned CW    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] q,
    input  logic       ta,
    input  logic       tb,
    input  logic       la,
    input  logic       lb,
    output logic [2:0] d,
    output logic       adv,
    output logic       req_al,
    output logic       req_bl
);

    typedef enum logic [2:0] {
        StAGrn     = 3'b000,
        StAYel     = 3'b001,
        StALeft    = 3'b010,
        StALeftYel = 3'b011,
        StBGrn     = 3'b100,
        StBYel     = 3'b101,
        StBLeft    = 3'b110,
        StBLeftYel = 3'b111
    } state_e;

    localparam logic [CW-1:0] CntMax = '1;
    localparam logic [CW-1:0] GMinT  = CW'(G_MIN - 1);
    localparam logic [CW-1:0] GMaxT  = CW'(G_MAX - 1);
    localparam logic [CW-1:0] YelT   = CW'(Y_T - 1);
    localparam logic [CW-1:0] LeftT  = CW'(L_T - 1);

    logic [2:0]    last_q_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] dwell;
    logic          req_al_q, req_al_d;
    logic          req_bl_q, req_bl_d;
    logic          a_done, b_done, yel_done, left_done;

    always_comb begin
        // Any change of q, whether caused here or forced from outside, restarts the dwell.
        dwell     = (q != last_q_q) ? '0 : cnt_q;
        cnt_d     = (dwell == CntMax) ? CntMax : dwell + 1'b1;
        a_done    = (dwell >= GMaxT) || (!ta && (dwell >= GMinT));
        b_done    = (dwell >= GMaxT) || (!tb && (dwell >= GMinT));
        yel_done  = (dwell >= YelT);
        left_done = (dwell >= LeftT);

        d = q;
        case (q)
            StAGrn:     if (a_done)    d = StAYel;
            StAYel:     if (yel_done)  d = (req_al_q | la) ? StALeft : StBGrn;
            StALeft:    if (left_done) d = StALeftYel;
            StALeftYel: if (yel_done)  d = StBGrn;
            StBGrn:     if (b_done)    d = StBYel;
            StBYel:     if (yel_done)  d = (req_bl_q | lb) ? StBLeft : StAGrn;
            StBLeft:    if (left_done) d = StBLeftYel;
            StBLeftYel: if (yel_done)  d = StAGrn;
            default:    d = q;
        endcase
        adv = (d != q);

        // Clearing while the left phase is being served takes priority over a new request.
        req_al_d = (q == StALeft) ? 1'b0 : (req_al_q | la);
        req_bl_d = (q == StBLeft) ? 1'b0 : (req_bl_q | lb);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q_q <= 3'b000;
            cnt_q    <= '0;
            req_al_q <= 1'b0;
            req_bl_q <= 1'b0;
        end else begin
            last_q_q <= q;
            cnt_q    <= cnt_d;
            req_al_q <= req_al_d;
            req_bl_q <= req_bl_d;
        end
    end

    assign req_al = req_al_q;
    assign req_bl = req_bl_q;

endmodule
